// File: rtl/mag_compare_seq.sv
// Iterative magnitude comparator for WIDTH-bit operands.
// Scans the operands MSB-first, DIGIT bits per clock, and stops at the first
// digit where they differ. In signed mode the operand MSBs are inverted at
// capture (offset binary), so the same unsigned scan gives two's-complement order.
//
// Handshakes use strict valid/ready semantics: a transfer happens on a rising
// edge where valid && ready are both 1. The producer holds valid (and data)
// until that edge. in_ready depends only on state and rst, never on in_valid.
// out_valid depends only on state. Once out_valid is raised it stays up,
// with its results held, until an out_ready handshake or a reset.
module mag_compare_seq #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 2,
    parameter int CW    = $clog2(WIDTH / DIGIT) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             signed_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             lt,
    output logic             eq,
    output logic             gt,
    output logic [CW-1:0]    cycles,
    output logic [1:0]       state_dbg
);

    localparam int NCHUNK = WIDTH / DIGIT;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic [CW-1:0]    k;
    logic [DIGIT-1:0] dig_a;
    logic [DIGIT-1:0] dig_b;

    // The digit being compared this cycle is always the top of the shift registers
    assign dig_a = sa[WIDTH-1 -: DIGIT];
    assign dig_b = sb[WIDTH-1 -: DIGIT];

    // Operands are accepted only while idle. The reset term makes in_ready
    // drop during any cycle in which reset is asserted.
    assign in_ready  = (state == IDLE) && !rst;
    assign state_dbg = state;

    // Control FSM with registered results; all state is cleared by reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            sa        <= '0;
            sb        <= '0;
            k         <= '0;
            out_valid <= 1'b0;
            lt        <= 1'b0;
            eq        <= 1'b0;
            gt        <= 1'b0;
            cycles    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        if (signed_mode) begin
                            sa <= {~a[WIDTH-1], a[WIDTH-2:0]};
                            sb <= {~b[WIDTH-1], b[WIDTH-2:0]};
                        end else begin
                            sa <= a;
                            sb <= b;
                        end
                        k     <= CW'(1);
                        state <= SCAN;
                    end
                end
                SCAN: begin
                    if (dig_a != dig_b) begin
                        lt        <= (dig_a < dig_b);
                        gt        <= (dig_a > dig_b);
                        eq        <= 1'b0;
                        cycles    <= k;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else if (k == CW'(NCHUNK)) begin
                        lt        <= 1'b0;
                        gt        <= 1'b0;
                        eq        <= 1'b1;
                        cycles    <= CW'(NCHUNK);
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        sa <= sa << DIGIT;
                        sb <= sb << DIGIT;
                        k  <= k + CW'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mag_compare_seq.sv
// Directed bench for mag_compare_seq. The main instance is WIDTH=16, DIGIT=2.
// A second instance, WIDTH=2, DIGIT=1, is checked over all operand pairs.
module tb_mag_compare_seq;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // 16-bit instance
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] a = '0;
    logic [15:0] b = '0;
    logic        signed_mode = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic        lt, eq, gt;
    logic [3:0]  cycles;
    logic [1:0]  state_dbg;

    mag_compare_seq #(.WIDTH(16), .DIGIT(2)) dut16 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .signed_mode(signed_mode), .out_valid(out_valid),
        .out_ready(out_ready), .lt(lt), .eq(eq), .gt(gt), .cycles(cycles),
        .state_dbg(state_dbg)
    );

    // 2-bit instance
    logic       iv2 = 1'b0;
    logic       ir2;
    logic [1:0] a2 = '0;
    logic [1:0] b2 = '0;
    logic       sm2 = 1'b0;
    logic       ov2;
    logic       or2 = 1'b1;
    logic       lt2, eq2, gt2;
    logic [1:0] cyc2;
    logic [1:0] st2;

    mag_compare_seq #(.WIDTH(2), .DIGIT(1)) dut2 (
        .clk(clk), .rst(rst), .in_valid(iv2), .in_ready(ir2),
        .a(a2), .b(b2), .signed_mode(sm2), .out_valid(ov2),
        .out_ready(or2), .lt(lt2), .eq(eq2), .gt(gt2), .cycles(cyc2),
        .state_dbg(st2)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called just after the accept edge: counts edges until out_valid, then checks results.
    task automatic wait_result(input string tag, input logic [2:0] exp_lge, input int exp_cyc);
        int  n;
        bit  seen_ready;
        bit  done;
        n = 0;
        seen_ready = 0;
        done = 0;
        while (n < 40 && !done) begin
            @(negedge clk);
            if (out_valid) done = 1;
            else begin
                if (in_ready) seen_ready = 1;
                n++;
            end
        end
        check({tag, "_latency"}, 32'(n), 32'(exp_cyc));
        check({tag, "_busy_in_ready"}, 32'(seen_ready), 32'd0);
        check({tag, "_lt_eq_gt"}, 32'({lt, eq, gt}), 32'(exp_lge));
        check({tag, "_cycles"}, 32'(cycles), 32'(exp_cyc));
    endtask

    // Starts at a negedge with the block idle; ends at a negedge idle again when drained.
    task automatic run_op(input string tag, input logic [15:0] va, input logic [15:0] vb,
                          input logic sm, input logic [2:0] exp_lge, input int exp_cyc,
                          input bit drain);
        check({tag, "_in_ready_idle"}, 32'(in_ready), 32'd1);
        a = va;
        b = vb;
        signed_mode = sm;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a = 16'($urandom);
        b = 16'($urandom);
        signed_mode = ~sm;
        wait_result(tag, exp_lge, exp_cyc);
        if (drain) begin
            @(negedge clk);
            check({tag, "_drained_out_valid"}, 32'(out_valid), 32'd0);
            check({tag, "_drained_in_ready"}, 32'(in_ready), 32'd1);
            check({tag, "_held_lt_eq_gt"}, 32'({lt, eq, gt}), 32'(exp_lge));
        end
    endtask

    task automatic run2(input logic [1:0] va, input logic [1:0] vb, input logic sm);
        int ia, ib, n;
        logic [2:0] exp_lge;
        int exp_cyc;
        bit done;
        string tag;
        tag = $sformatf("w2_a%0d_b%0d_s%0d", va, vb, sm);
        ia = (sm && va[1]) ? int'(va) - 4 : int'(va);
        ib = (sm && vb[1]) ? int'(vb) - 4 : int'(vb);
        exp_lge = {ia < ib, ia == ib, ia > ib};
        exp_cyc = (va[1] != vb[1]) ? 1 : 2;
        check({tag, "_in_ready"}, 32'(ir2), 32'd1);
        a2 = va;
        b2 = vb;
        sm2 = sm;
        iv2 = 1'b1;
        @(posedge clk);
        #1;
        iv2 = 1'b0;
        a2 = ~va;
        b2 = ~vb;
        n = 0;
        done = 0;
        while (n < 10 && !done) begin
            @(negedge clk);
            if (ov2) done = 1;
            else n++;
        end
        check({tag, "_latency"}, 32'(n), 32'(exp_cyc));
        check({tag, "_lt_eq_gt"}, 32'({lt2, eq2, gt2}), 32'(exp_lge));
        check({tag, "_cycles"}, 32'(cyc2), 32'(exp_cyc));
        @(negedge clk);
        check({tag, "_drained"}, 32'(ov2), 32'd0);
    endtask

    initial begin
        // Reset state
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_in_ready", 32'(in_ready), 32'd0);
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_lt_eq_gt", 32'({lt, eq, gt}), 32'd0);
        check("reset_cycles", 32'(cycles), 32'd0);
        rst = 1'b0;
        #1;
        check("reset_release_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);

        // Directed vectors, out_ready held 1
        run_op("early_exit",   16'h8000, 16'h7FFF, 1'b0, 3'b001, 1, 1);
        run_op("full_eq",      16'h1234, 16'h1234, 1'b0, 3'b010, 8, 1);
        run_op("last_chunk",   16'h1230, 16'h1231, 1'b0, 3'b100, 8, 1);
        run_op("signed_neg",   16'hFFFF, 16'h0001, 1'b1, 3'b100, 1, 1);
        run_op("unsigned_big", 16'hFFFF, 16'h0001, 1'b0, 3'b001, 1, 1);
        run_op("signed_min",   16'h8000, 16'h8001, 1'b1, 3'b100, 8, 1);
        run_op("signed_pos",   16'h0005, 16'hFFFE, 1'b1, 3'b001, 1, 1);

        // Backpressure: result 0x0005 vs 0x0003 differs in chunk 7
        out_ready = 1'b0;
        run_op("bp_first", 16'h0005, 16'h0003, 1'b0, 3'b001, 7, 0);
        a = 16'h0001;
        b = 16'h0002;
        signed_mode = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_out_valid", 32'(out_valid), 32'd1);
            check("bp_lt_eq_gt", 32'({lt, eq, gt}), 32'b001);
            check("bp_cycles", 32'(cycles), 32'd7);
            check("bp_in_ready", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        check("bp_after_hs_in_ready", 32'(in_ready), 32'd1);
        check("bp_after_hs_out_valid", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a = 16'hFFFF;
        b = 16'h0000;
        wait_result("bp_second", 3'b100, 8);
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_second_drained", 32'(out_valid), 32'd0);

        // Reset on the 3rd SCAN cycle of an equal compare
        a = 16'h1234;
        b = 16'h1234;
        signed_mode = 1'b0;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_lt_eq_gt", 32'({lt, eq, gt}), 32'd0);
        check("midrst_cycles", 32'(cycles), 32'd0);
        check("midrst_in_ready", 32'(in_ready), 32'd0);
        rst = 1'b0;
        #1;
        check("midrst_release_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        check("midrst_no_result", 32'(out_valid), 32'd0);
        run_op("after_rst", 16'h0003, 16'h0002, 1'b0, 3'b001, 8, 1);

        // Exhaustive WIDTH=2, DIGIT=1
        for (int s = 0; s < 2; s++)
            for (int i = 0; i < 4; i++)
                for (int j = 0; j < 4; j++)
                    run2(2'(i), 2'(j), 1'(s));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global time limit so the run always ends with a summary
    initial begin
        #200000;
        failures++;
        $display("FAIL timeout: got no finish expected finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
